// File: rtl/jt51_modmix.sv
// -----------------------------------------------------------------------------
// jt51_modmix
//
// Phase-modulation mixer for a 32-slot FM operator pipeline. Every operator
// result is pushed into a 32-deep history so that a later slot can pick up the
// output of an operator 8, 16 or 24 slots earlier. M1 operators additionally
// keep the last two outputs of their own channel for self-feedback.
//
// Slot layout: slot[4:3] selects the operator group (0=M1, 1=M2, 2=C1, 3=C2),
// slot[2:0] selects the channel.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   cen            slot clock enable; nothing advances while low
//   zero           current slot is slot 0 (frame sync)
//   fb[2:0]        M1 feedback level of the current channel, 0 = off
//   use_prevprev1  source select: H[24] (M1: feedback)
//   use_prev1      source select: H[8]  (M1: feedback)
//   use_prev2      source select: H[16]
//   use_internal_x source select: H[24]
//   use_internal_y source select: H[16]
//   op_result      signed operator output of the current slot
//   mod_out        registered signed modulation input for the phase adder
//   slot           current slot index
// -----------------------------------------------------------------------------
module jt51_modmix #(
    parameter int W  = 14,
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic                 zero,
    input  logic [2:0]           fb,
    input  logic                 use_prevprev1,
    input  logic                 use_prev1,
    input  logic                 use_prev2,
    input  logic                 use_internal_x,
    input  logic                 use_internal_y,
    input  logic signed [W-1:0]  op_result,
    output logic signed [OW-1:0] mod_out,
    output logic [4:0]           slot
);

    localparam int HLEN = 32;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [4:0]           slot_q, slot_d;
    logic signed [OW-1:0] mod_q, mod_d;
    // hist_q[k] holds the operator result committed k slots ago (k = 1..32)
    logic signed [W-1:0]  hist_q [1:HLEN];
    // Per-channel M1 feedback: fb0 = most recent M1 output, fb1 = the one before
    logic signed [W-1:0]  fb0_q  [0:7];
    logic signed [W-1:0]  fb1_q  [0:7];

    // -------------------------------------------------------------------------
    // Slot decode; zero forces the decision slot to 0 on this edge
    // -------------------------------------------------------------------------
    logic [4:0] eff_slot;
    logic [1:0] grp;
    logic [2:0] ch;
    logic       is_m1;

    always_comb begin
        eff_slot = zero ? 5'd0 : slot_q;
        grp      = eff_slot[4:3];
        ch       = eff_slot[2:0];
        is_m1    = (grp == 2'd0);
        // Increment of the forced 0 is 1; natural 5-bit overflow wraps 31->0
        slot_d   = zero ? 5'd1 : slot_q + 5'd1;
    end

    // -------------------------------------------------------------------------
    // Tap extraction, sign-extended to the output width
    // -------------------------------------------------------------------------
    logic signed [OW-1:0] tap8_ext, tap16_ext, tap24_ext;

    always_comb begin
        tap8_ext  = {{(OW-W){hist_q[8][W-1]}},  hist_q[8]};
        tap16_ext = {{(OW-W){hist_q[16][W-1]}}, hist_q[16]};
        tap24_ext = {{(OW-W){hist_q[24][W-1]}}, hist_q[24]};
    end

    // -------------------------------------------------------------------------
    // M1 self-feedback term
    // The pair sum needs one extra bit; the level maps to a right shift of
    // 7-fb so fb=7 passes the full sum and fb=1 divides it by 64.
    // -------------------------------------------------------------------------
    logic signed [W:0]    fb_sum;
    logic signed [W:0]    fb_shifted;
    logic [2:0]           fb_shamt;
    logic signed [OW-1:0] fb_term;

    always_comb begin
        fb_sum     = {fb0_q[ch][W-1], fb0_q[ch]} + {fb1_q[ch][W-1], fb1_q[ch]};
        fb_shamt   = 3'd7 - fb;
        fb_shifted = fb_sum >>> fb_shamt;
        if (fb == 3'd0) begin
            fb_term = '0;
        end else begin
            fb_term = {{(OW-W-1){fb_shifted[W]}}, fb_shifted};
        end
    end

    // -------------------------------------------------------------------------
    // Modulation source mix
    // -------------------------------------------------------------------------
    always_comb begin
        mod_d = '0;
        if (is_m1) begin
            // M1 only ever modulates itself; other selects are meaningless here
            if (use_prev1 || use_prevprev1) begin
                mod_d = fb_term;
            end
        end else begin
            if (use_prev1) begin
                mod_d = mod_d + tap8_ext;
            end
            if (use_prev2) begin
                mod_d = mod_d + tap16_ext;
            end
            if (use_prevprev1) begin
                mod_d = mod_d + tap24_ext;
            end
            if (use_internal_x) begin
                mod_d = mod_d + tap24_ext;
            end
            if (use_internal_y) begin
                mod_d = mod_d + tap16_ext;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Slot counter and output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= 5'd0;
            mod_q  <= '0;
        end else if (cen) begin
            slot_q <= slot_d;
            mod_q  <= mod_d;
        end
    end

    // -------------------------------------------------------------------------
    // History shift register. Taps above are read from the pre-shift contents.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= HLEN; k++) begin
                hist_q[k] <= '0;
            end
        end else if (cen) begin
            hist_q[1] <= op_result;
            for (int k = 2; k <= HLEN; k++) begin
                hist_q[k] <= hist_q[k-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // M1 feedback pairs, updated only on the channel's M1 slot
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 8; c++) begin
                fb0_q[c] <= '0;
                fb1_q[c] <= '0;
            end
        end else if (cen && is_m1) begin
            fb1_q[ch] <= fb0_q[ch];
            fb0_q[ch] <= op_result;
        end
    end

    assign mod_out = mod_q;
    assign slot    = slot_q;

endmodule

// File: tb/tb_jt51_modmix.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for jt51_modmix.
// -----------------------------------------------------------------------------
module tb_jt51_modmix;

    logic               clk;
    logic               rst_n;
    logic               cen;
    logic               zero;
    logic [2:0]         fb;
    logic               use_prevprev1;
    logic               use_prev1;
    logic               use_prev2;
    logic               use_internal_x;
    logic               use_internal_y;
    logic signed [13:0] op_result;
    logic signed [15:0] mod_out;
    logic [4:0]         slot;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cur     = 0;   // expected slot index, used to navigate the frame

    jt51_modmix #(.W(14), .OW(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cen            (cen),
        .zero           (zero),
        .fb             (fb),
        .use_prevprev1  (use_prevprev1),
        .use_prev1      (use_prev1),
        .use_prev2      (use_prev2),
        .use_internal_x (use_internal_x),
        .use_internal_y (use_internal_y),
        .op_result      (op_result),
        .mod_out        (mod_out),
        .slot           (slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        zero           = 1'b0;
        fb             = 3'd0;
        use_prevprev1  = 1'b0;
        use_prev1      = 1'b0;
        use_prev2      = 1'b0;
        use_internal_x = 1'b0;
        use_internal_y = 1'b0;
    endtask

    // One enabled slot; controls set by the caller apply to this slot only.
    task automatic step(input int op);
        logic z;
        z         = zero;
        op_result = 14'(op);
        cen       = 1'b1;
        @(posedge clk);
        #1;
        cen = 1'b0;
        clear_ctl();
        cur = z ? 1 : (cur + 1) % 32;
        $display("slot_step op=%0d -> slot=%0d mod_out=%0d", op, slot, mod_out);
    endtask

    task automatic run(input int n, input int op);
        for (int i = 0; i < n; i++) step(op);
    endtask

    task automatic goto_slot(input int target, input int op);
        for (int i = 0; i < 32 && cur != target; i++) step(op);
    endtask

    initial begin
        rst_n     = 1'b0;
        cen       = 1'b0;
        op_result = '0;
        clear_ctl();

        // ---------------- reset state ----------------
        #12;
        check("reset_slot", {27'd0, slot}, 0);
        check("reset_mod", 32'(mod_out), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ---------------- free run, all selects 0, wrap ----------------
        run(40, 100);
        check("run40_mod_zero", 32'(mod_out), 0);
        check("run40_slot_wrap", {27'd0, slot}, 8);
        use_prev1 = 1'b1;
        step(100);                                 // slot 8, H[8]=100
        check("pre_reset_prev1", 32'(mod_out), 100);

        // ---------------- asynchronous reset mid-frame ----------------
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_slot", {27'd0, slot}, 0);
        check("async_rst_mod", 32'(mod_out), 0);
        cur = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        fb = 3'd7; use_prev1 = 1'b1;
        step(0);                                   // slot 0: fb pair must be cleared
        check("fb_pair_cleared", 32'(mod_out), 0);
        run(7, 0);                                 // slots 1..7
        use_internal_x = 1'b1; use_internal_y = 1'b1; use_prevprev1 = 1'b1;
        step(0);                                   // slot 8: H[16], H[24] from reset
        check("history_cleared", 32'(mod_out), 0);

        // ---------------- prev1 / prev2 taps, cen gating ----------------
        zero = 1'b1;
        step(0);                                   // sync from slot 9
        check("sync_slot1", {27'd0, slot}, 1);
        for (int e = 1; e <= 8; e++) step(e * 10);
        check("slot_before_gate", {27'd0, slot}, 9);

        use_prev1 = 1'b1; use_internal_x = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op_result = 14'($urandom_range(1000, 1));
            @(posedge clk); #1;
        end
        check("gate_slot_hold", {27'd0, slot}, 9);
        check("gate_mod_hold", 32'(mod_out), 0);
        clear_ctl();

        use_prev1 = 1'b1;
        step(90);                                  // slot 9: H[8] = slot 1 value
        check("prev1_tap", 32'(mod_out), 10);
        for (int e = 10; e <= 16; e++) step(e * 10);
        use_prev2 = 1'b1;
        step(170);                                 // slot 17: H[16] = slot 1
        check("prev2_tap", 32'(mod_out), 10);
        use_prev1 = 1'b1; use_prev2 = 1'b1;
        step(180);                                 // slot 18: 100 + 20
        check("prev1_prev2_sum", 32'(mod_out), 120);

        goto_slot(0, 0);
        check("wrap_to_0", {27'd0, slot}, 0);

        // ---------------- triple sum in C2 ----------------
        use_internal_x = 1'b1; use_prev2 = 1'b1;
        step(-5);                                  // slot 0, M1 ignores non-fb selects
        check("m1_ignores_selects", 32'(mod_out), 0);
        step(-300);                                // slot 1
        goto_slot(8, 0);
        step(7);
        goto_slot(16, 0);
        step(3);
        goto_slot(24, 0);
        use_prev1 = 1'b1; use_internal_x = 1'b1; use_internal_y = 1'b1;
        step(0);                                   // 3 + (-5) + 7
        check("triple_sum", 32'(mod_out), 5);
        use_internal_x = 1'b1;
        step(0);                                   // slot 25: H[24] = -300
        check("neg_internal_x", 32'(mod_out), -300);

        // ---------------- M1 feedback ----------------
        goto_slot(0, 0); step(4000);
        goto_slot(0, 0); step(2000);
        goto_slot(0, 0);
        fb = 3'd7; use_prev1 = 1'b1; use_prevprev1 = 1'b1;
        step(4000);
        check("fb7", 32'(mod_out), 6000);
        goto_slot(0, 0);
        fb = 3'd1; use_prev1 = 1'b1; use_prevprev1 = 1'b1;
        step(2000);
        check("fb1", 32'(mod_out), 93);
        goto_slot(0, 0);
        fb = 3'd0; use_prev1 = 1'b1; use_prevprev1 = 1'b1;
        step(4000);
        check("fb0_off", 32'(mod_out), 0);
        goto_slot(0, 0);
        fb = 3'd7; use_prevprev1 = 1'b1;
        step(4000);
        check("fb7_prevprev1_only", 32'(mod_out), 6000);

        // ---------------- zero forced at slot 17 ----------------
        goto_slot(17, 0);
        check("at_slot17", {27'd0, slot}, 17);
        zero = 1'b1; fb = 3'd7; use_prev1 = 1'b1;
        step(0);                                   // decoded as M1 ch0: 4000+4000
        check("zero_forces_m1", 32'(mod_out), 8000);
        check("zero_slot_next", {27'd0, slot}, 1);
        goto_slot(0, 0);
        fb = 3'd3; use_prev1 = 1'b1;
        step(0);                                   // pair now 0 + 4000, >>> 4
        check("fb3_after_zero", 32'(mod_out), 250);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
